// File: rtl/wisc_pkg.sv
// Shared opcode, condition-code, flag-index and FSM definitions for the WISC core.
// Used by flag_branch_unit and branch_cond_eval.
package wisc_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_LW     = 4'b1000;
  localparam logic [3:0] OP_SW     = 4'b1001;
  localparam logic [3:0] OP_LLB    = 4'b1010;
  localparam logic [3:0] OP_LHB    = 4'b1011;
  localparam logic [3:0] OP_B      = 4'b1100;
  localparam logic [3:0] OP_BR     = 4'b1101;
  localparam logic [3:0] OP_PCS    = 4'b1110;
  localparam logic [3:0] OP_HLT    = 4'b1111;

  localparam logic [2:0] CC_NE  = 3'b000;
  localparam logic [2:0] CC_EQ  = 3'b001;
  localparam logic [2:0] CC_GT  = 3'b010;
  localparam logic [2:0] CC_LT  = 3'b011;
  localparam logic [2:0] CC_GE  = 3'b100;
  localparam logic [2:0] CC_LE  = 3'b101;
  localparam logic [2:0] CC_OV  = 3'b110;
  localparam logic [2:0] CC_UNC = 3'b111;

  localparam int FLG_Z = 2;
  localparam int FLG_V = 1;
  localparam int FLG_N = 0;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  // Arithmetic ops own all three flags; logical/shift ops only own Z.
  function automatic logic [2:0] flagWriteMask(input logic [3:0] opcode);
    logic [2:0] mask;
    mask = 3'b000;
    case (opcode)
      OP_ADD, OP_SUB:                 mask = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: mask[FLG_Z] = 1'b1;
      default:                        mask = 3'b000;
    endcase
    return mask;
  endfunction

  function automatic logic isBranchOpcode(input logic [3:0] opcode);
    return (opcode == OP_B) || (opcode == OP_BR);
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational resolution of a 3-bit branch condition code against the Z/V/N flags.
module branch_cond_eval
  import wisc_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic [2:0] flags_i,
  output logic       taken_o
);

  logic zFlag;
  logic vFlag;
  logic nFlag;

  assign zFlag = flags_i[FLG_Z];
  assign vFlag = flags_i[FLG_V];
  assign nFlag = flags_i[FLG_N];

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      CC_NE:   taken_o = !zFlag;
      CC_EQ:   taken_o = zFlag;
      CC_GT:   taken_o = !zFlag && !nFlag;
      CC_LT:   taken_o = nFlag;
      CC_GE:   taken_o = zFlag || (!zFlag && !nFlag);
      CC_LE:   taken_o = nFlag || zFlag;
      CC_OV:   taken_o = vFlag;
      CC_UNC:  taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Flag register, branch resolution and halt tracking at the ALU/PC boundary.
// Define FLAG_BYPASS_EN to let branches see same-cycle ALU flag writes.
module flag_branch_unit
  import wisc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              alu_valid,
  input  logic [3:0]        alu_opcode,
  input  logic [2:0]        alu_flag,
  input  logic              br_valid,
  input  logic [3:0]        br_opcode,
  input  logic [2:0]        br_cond,
  input  logic [IMM_W-1:0]  br_imm,
  input  logic [DATA_W-1:0] br_reg,
  input  logic [DATA_W-1:0] pc_plus2,
  input  logic              hlt_valid,
  output logic [2:0]        flag_q,
  output logic              br_done,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target,
  output logic              halted
);

  state_e            state_q;
  logic              acceptNow;
  logic [2:0]        aluMask;
  logic [2:0]        flag_d;
  logic [2:0]        evalFlags;
  logic              branchReq;
  logic              condTaken;
  logic [DATA_W-1:0] immExt;
  logic [DATA_W-1:0] bTarget;
  logic [DATA_W-1:0] takenTarget;

  assign acceptNow = !stall && (state_q == RUN);

  assign aluMask = (acceptNow && alu_valid) ? flagWriteMask(alu_opcode) : 3'b000;
  assign flag_d  = (flag_q & ~aluMask) | (alu_flag & aluMask);

`ifdef FLAG_BYPASS_EN
  assign evalFlags = flag_d;
`else
  assign evalFlags = flag_q;
`endif

  assign branchReq = br_valid && isBranchOpcode(br_opcode);

  // Immediate is a word offset; wrap-around past the top of the address space is intended.
  assign immExt      = {{(DATA_W-IMM_W){br_imm[IMM_W-1]}}, br_imm};
  assign bTarget     = pc_plus2 + (immExt << 1);
  assign takenTarget = (br_opcode == OP_BR) ? br_reg : bTarget;

  branch_cond_eval u_cond (
    .cond_i  (br_cond),
    .flags_i (evalFlags),
    .taken_o (condTaken)
  );

  assign halted = (state_q == HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      flag_q    <= 3'b000;
      br_done   <= 1'b0;
      br_taken  <= 1'b0;
      br_target <= '0;
    end else begin
      br_done <= 1'b0;
      if (acceptNow) begin
        flag_q <= flag_d;
        if (branchReq) begin
          br_done   <= 1'b1;
          br_taken  <= condTaken;
          br_target <= condTaken ? takenTarget : pc_plus2;
        end
        if (hlt_valid) begin
          state_q <= HALTED;
        end
      end
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Self-checking bench for flag_branch_unit: directed scenarios plus randomized traffic
// against a behavioural flag/branch model. Honors FLAG_BYPASS_EN when defined.
module tb_flag_branch_unit;

  localparam int DATA_W = 16;
  localparam int IMM_W  = 9;

  logic              clk;
  logic              rst_n;
  logic              stall;
  logic              alu_valid;
  logic [3:0]        alu_opcode;
  logic [2:0]        alu_flag;
  logic              br_valid;
  logic [3:0]        br_opcode;
  logic [2:0]        br_cond;
  logic [IMM_W-1:0]  br_imm;
  logic [DATA_W-1:0] br_reg;
  logic [DATA_W-1:0] pc_plus2;
  logic              hlt_valid;
  logic [2:0]        flag_q;
  logic              br_done;
  logic              br_taken;
  logic [DATA_W-1:0] br_target;
  logic              halted;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  bit          mZ, mV, mN;
  bit          mHalted, mDone, mTaken;
  logic [15:0] mTarget;

  flag_branch_unit #(.DATA_W(DATA_W), .IMM_W(IMM_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .alu_valid  (alu_valid),
    .alu_opcode (alu_opcode),
    .alu_flag   (alu_flag),
    .br_valid   (br_valid),
    .br_opcode  (br_opcode),
    .br_cond    (br_cond),
    .br_imm     (br_imm),
    .br_reg     (br_reg),
    .pc_plus2   (pc_plus2),
    .hlt_valid  (hlt_valid),
    .flag_q     (flag_q),
    .br_done    (br_done),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit condHolds(int cc, bit z, bit v, bit n);
    case (cc)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || (!z && !n);
      5: return n || z;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [15:0] bTargetOf(int pc, int imm);
    int offset;
    offset = (imm >= (1 << (IMM_W-1))) ? imm - (1 << IMM_W) : imm;
    return 16'((pc + 2 * offset) & 32'hFFFF);
  endfunction

  task automatic resetModel();
    mZ = 0; mV = 0; mN = 0;
    mHalted = 0; mDone = 0; mTaken = 0; mTarget = 16'h0000;
  endtask

  // Advance one clock; the model consumes the same inputs the DUT sees at the edge.
  task automatic cycle();
    bit acc, wz, wvn, nz, nv, nn, ez, ev, en, doneNext, takenNext, haltNext;
    logic [15:0] targetNext;
    int op;
    op  = int'(alu_opcode);
    acc = !stall && !mHalted;
    wz  = acc && alu_valid && (op == 0 || op == 1 || op == 2 || op == 4 || op == 5 || op == 6);
    wvn = acc && alu_valid && (op == 0 || op == 1);
    nz  = wz  ? alu_flag[2] : mZ;
    nv  = wvn ? alu_flag[1] : mV;
    nn  = wvn ? alu_flag[0] : mN;
`ifdef FLAG_BYPASS_EN
    ez = nz; ev = nv; en = nn;
`else
    ez = mZ; ev = mV; en = mN;
`endif
    doneNext   = acc && br_valid && (br_opcode == 4'd12 || br_opcode == 4'd13);
    takenNext  = mTaken;
    targetNext = mTarget;
    if (doneNext) begin
      takenNext = condHolds(int'(br_cond), ez, ev, en);
      if (!takenNext)              targetNext = pc_plus2;
      else if (br_opcode == 4'd13) targetNext = br_reg;
      else                         targetNext = bTargetOf(int'(pc_plus2), int'(br_imm));
    end
    haltNext = mHalted || (acc && hlt_valid);
    @(posedge clk);
    #1;
    mZ = nz; mV = nv; mN = nn;
    mDone = doneNext; mTaken = takenNext; mTarget = targetNext; mHalted = haltNext;
  endtask

  task automatic idleInputs();
    stall = 0; alu_valid = 0; alu_opcode = 4'd0; alu_flag = 3'b000;
    br_valid = 0; br_opcode = 4'd0; br_cond = 3'b000; br_imm = '0;
    br_reg = '0; pc_plus2 = '0; hlt_valid = 0;
  endtask

  task automatic aluOp(input logic [3:0] op, input logic [2:0] flg);
    idleInputs();
    alu_valid = 1; alu_opcode = op; alu_flag = flg;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idleInputs();
    resetModel();
    #12;
    if (flag_q !== 3'b000) begin failures++; $display("[TB] FAIL reset_flag: got %b want 000", flag_q); end
    checks++;
    if (br_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b want 0", br_done); end
    checks++;
    if (br_target !== 16'h0000 || br_taken !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_branch: taken=%b target=%h want 0/0000", br_taken, br_target);
    end
    checks++;
    if (halted !== 1'b0) begin failures++; $display("[TB] FAIL reset_halted: got %b want 0", halted); end
    checks++;
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_flags();
    aluOp(4'b0000, 3'b111);
    cycle();
    if (flag_q !== 3'b111) begin failures++; $display("[TB] FAIL flags_add: got %b want 111", flag_q); end
    checks++;
    aluOp(4'b0010, 3'b000);
    cycle();
    if (flag_q !== 3'b011) begin failures++; $display("[TB] FAIL flags_xor: got %b want 011", flag_q); end
    checks++;
    aluOp(4'b1000, 3'b000);
    cycle();
    if (flag_q !== 3'b011) begin failures++; $display("[TB] FAIL flags_nowrite: got %b want 011", flag_q); end
    checks++;
  endtask

  task automatic test_branch_b();
    aluOp(4'b0000, 3'b100);
    cycle();
    idleInputs();
    br_valid = 1; br_opcode = 4'b1100; br_cond = 3'b001; pc_plus2 = 16'h0010; br_imm = 9'h1FE;
    cycle();
    if (br_done !== 1'b1 || br_taken !== 1'b1 || br_target !== 16'h000C) begin
      failures++;
      $display("[TB] FAIL b_eq_taken: done=%b taken=%b target=%h want 1/1/000C", br_done, br_taken, br_target);
    end
    checks++;
    idleInputs();
    cycle();
    if (br_done !== 1'b0 || br_taken !== 1'b1 || br_target !== 16'h000C) begin
      failures++;
      $display("[TB] FAIL b_hold: done=%b taken=%b target=%h want 0/1/000C", br_done, br_taken, br_target);
    end
    checks++;
  endtask

  task automatic test_branch_br();
    aluOp(4'b0000, 3'b000);
    cycle();
    idleInputs();
    br_valid = 1; br_opcode = 4'b1101; br_cond = 3'b011; br_reg = 16'h4000; pc_plus2 = 16'h0100;
    cycle();
    if (br_done !== 1'b1 || br_taken !== 1'b0 || br_target !== 16'h0100) begin
      failures++;
      $display("[TB] FAIL br_lt_not_taken: done=%b taken=%b target=%h want 1/0/0100", br_done, br_taken, br_target);
    end
    checks++;
    br_cond = 3'b111;
    cycle();
    if (br_done !== 1'b1 || br_taken !== 1'b1 || br_target !== 16'h4000) begin
      failures++;
      $display("[TB] FAIL br_unc_taken: done=%b taken=%b target=%h want 1/1/4000", br_done, br_taken, br_target);
    end
    checks++;
    br_opcode = 4'b1110;
    cycle();
    if (br_done !== 1'b0) begin failures++; $display("[TB] FAIL br_bad_opcode: done=%b want 0", br_done); end
    checks++;
  endtask

  task automatic test_simultaneous();
    logic        expTaken;
    logic [15:0] expTarget;
`ifdef FLAG_BYPASS_EN
    expTaken = 1'b1; expTarget = 16'h0028;
`else
    expTaken = 1'b0; expTarget = 16'h0020;
`endif
    aluOp(4'b0000, 3'b000);
    cycle();
    aluOp(4'b0001, 3'b100);
    br_valid = 1; br_opcode = 4'b1100; br_cond = 3'b001; pc_plus2 = 16'h0020; br_imm = 9'h004;
    cycle();
    if (br_done !== 1'b1 || br_taken !== expTaken || br_target !== expTarget) begin
      failures++;
      $display("[TB] FAIL simul_branch: done=%b taken=%b target=%h want 1/%b/%h",
               br_done, br_taken, br_target, expTaken, expTarget);
    end
    checks++;
    if (flag_q !== 3'b100) begin failures++; $display("[TB] FAIL simul_flags: got %b want 100", flag_q); end
    checks++;
  endtask

  task automatic test_stall();
    logic [2:0] held;
    held = flag_q;
    aluOp(4'b0000, 3'b111);
    br_valid = 1; br_opcode = 4'b1100; br_cond = 3'b111; pc_plus2 = 16'h0200; br_imm = 9'h010;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (br_done !== 1'b0 || flag_q !== held) begin
        failures++;
        $display("[TB] FAIL stall_hold[%0d]: done=%b flag=%b want 0/%b", i, br_done, flag_q, held);
      end
      checks++;
    end
    stall = 0;
    cycle();
    if (br_done !== 1'b1 || br_taken !== 1'b1 || br_target !== 16'h0220 || flag_q !== 3'b111) begin
      failures++;
      $display("[TB] FAIL stall_release: done=%b taken=%b target=%h flag=%b want 1/1/0220/111",
               br_done, br_taken, br_target, flag_q);
    end
    checks++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      idleInputs();
      stall      = ($urandom_range(0, 3) == 0);
      alu_valid  = ($urandom_range(0, 1) == 1);
      alu_opcode = 4'($urandom_range(0, 15));
      alu_flag   = 3'($urandom_range(0, 7));
      br_valid   = ($urandom_range(0, 2) != 0);
      br_opcode  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'(12 + $urandom_range(0, 1));
      br_cond    = 3'($urandom_range(0, 7));
      br_imm     = 9'($urandom);
      br_reg     = 16'($urandom);
      pc_plus2   = 16'($urandom);
      cycle();
      if (flag_q !== {mZ, mV, mN}) begin
        failures++; $display("[TB] FAIL rand_flag[%0d]: got %b want %b", i, flag_q, {mZ, mV, mN});
      end
      checks++;
      if (br_done !== mDone || br_taken !== mTaken || br_target !== mTarget) begin
        failures++;
        $display("[TB] FAIL rand_branch[%0d]: done=%b taken=%b target=%h want %b/%b/%h",
                 i, br_done, br_taken, br_target, mDone, mTaken, mTarget);
      end
      checks++;
      if (halted !== mHalted) begin
        failures++; $display("[TB] FAIL rand_halted[%0d]: got %b want %b", i, halted, mHalted);
      end
      checks++;
    end
  endtask

  task automatic test_halt();
    aluOp(4'b0000, 3'b111);
    hlt_valid = 1;
    cycle();
    if (halted !== 1'b1 || flag_q !== 3'b111) begin
      failures++; $display("[TB] FAIL halt_enter: halted=%b flag=%b want 1/111", halted, flag_q);
    end
    checks++;
    aluOp(4'b0000, 3'b000);
    br_valid = 1; br_opcode = 4'b1100; br_cond = 3'b111; pc_plus2 = 16'h0300;
    for (int i = 0; i < 2; i++) begin
      cycle();
      if (halted !== 1'b1 || flag_q !== 3'b111 || br_done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL halt_ignore[%0d]: halted=%b flag=%b done=%b want 1/111/0", i, halted, flag_q, br_done);
      end
      checks++;
    end
    #3;
    rst_n = 0;
    #1;
    if (halted !== 1'b0 || flag_q !== 3'b000 || br_done !== 1'b0 || br_taken !== 1'b0 || br_target !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL async_reset: halted=%b flag=%b done=%b taken=%b target=%h want all 0",
               halted, flag_q, br_done, br_taken, br_target);
    end
    checks++;
    resetModel();
    idleInputs();
    #2;
    rst_n = 1;
    @(posedge clk);
    #1;
    aluOp(4'b0001, 3'b010);
    cycle();
    if (flag_q !== 3'b010 || halted !== 1'b0) begin
      failures++; $display("[TB] FAIL post_reset_run: flag=%b halted=%b want 010/0", flag_q, halted);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_flags();
    test_branch_b();
    test_branch_br();
    test_simultaneous();
    test_stall();
    test_random();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
